// File: rtl/ddr_rx_word_collector_if.sv
// Handshake/data bundle between the CCC handler path and the RX word collector.
// master drives framing, byte stream and pops; slave is the collector.
interface ddr_rx_word_collector_if #(
    parameter int FIFO_AW = 3
);
    logic                 i_frame_start;
    logic                 i_frame_end;
    logic [7:0]           i_rx_data;
    logic                 i_rx_data_valid;
    logic                 i_rx_error;
    logic                 i_rd_en;
    logic [15:0]          o_rd_data;
    logic                 o_fifo_empty;
    logic                 o_fifo_full;
    logic [FIFO_AW:0]     o_word_count;
    logic                 o_overflow;
    logic                 o_odd_byte;
    logic                 o_frame_error;
    logic                 o_frame_done;

    modport master (
        output i_frame_start, i_frame_end, i_rx_data,
        output i_rx_data_valid, i_rx_error, i_rd_en,
        input  o_rd_data, o_fifo_empty, o_fifo_full,
        input  o_word_count, o_overflow, o_odd_byte,
        input  o_frame_error, o_frame_done
    );

    modport slave (
        input  i_frame_start, i_frame_end, i_rx_data,
        input  i_rx_data_valid, i_rx_error, i_rd_en,
        output o_rd_data, o_fifo_empty, o_fifo_full,
        output o_word_count, o_overflow, o_odd_byte,
        output o_frame_error, o_frame_done
    );
endinterface

// File: rtl/ddr_rx_word_collector.sv
// HDR-DDR RX word collector: pairs MSB/LSB bytes into 16-bit words in a show-ahead FIFO.
// Optional RX_COLLECT_PAD_EN: unpaired MSB at frame close is written as {msb,8'h00}.
module ddr_rx_word_collector #(
    parameter int FIFO_AW = 3
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    ddr_rx_word_collector_if.slave  bus
);
    localparam int DEPTH_I = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MSB,
        WAIT_LSB,
        DONE
    } state_t;

    state_t               state_q;
    state_t               state_n;
    logic [7:0]           msb_q;
    logic [15:0]          mem [DEPTH_I];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count_q;
    logic                 ovf_q;
    logic                 odd_q;
    logic                 err_q;

    logic                 clr;
    logic                 msb_ld;
    logic                 push_req;
    logic [15:0]          push_data;
    logic                 set_odd;
    logic                 set_err;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 push_ok;

    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == '0);
    assign pop     = bus.i_rd_en && !empty;
    assign push_ok = push_req && (!full || pop);

    // Framing state register.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) state_q <= IDLE;
        else            state_q <= state_n;
    end

    // Next state and per-cycle actions; a byte arriving with frame_end is consumed first.
    always_comb begin
        state_n   = state_q;
        clr       = 1'b0;
        msb_ld    = 1'b0;
        push_req  = 1'b0;
        push_data = 16'h0000;
        set_odd   = 1'b0;
        set_err   = 1'b0;
        if (bus.i_frame_start) begin
            clr     = 1'b1;
            state_n = WAIT_MSB;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_n = IDLE;
                end
                WAIT_MSB: begin
                    set_err = bus.i_rx_error;
                    if (bus.i_rx_data_valid) begin
                        msb_ld = 1'b1;
                        if (bus.i_frame_end) begin
                            set_odd = 1'b1;
                            state_n = DONE;
`ifdef RX_COLLECT_PAD_EN
                            push_req  = 1'b1;
                            push_data = {bus.i_rx_data, 8'h00};
`endif
                        end else begin
                            state_n = WAIT_LSB;
                        end
                    end else if (bus.i_frame_end) begin
                        state_n = DONE;
                    end
                end
                WAIT_LSB: begin
                    set_err = bus.i_rx_error;
                    if (bus.i_rx_data_valid) begin
                        push_req  = 1'b1;
                        push_data = {msb_q, bus.i_rx_data};
                        state_n   = bus.i_frame_end ? DONE : WAIT_MSB;
                    end else if (bus.i_frame_end) begin
                        set_odd = 1'b1;
                        state_n = DONE;
`ifdef RX_COLLECT_PAD_EN
                        push_req  = 1'b1;
                        push_data = {msb_q, 8'h00};
`endif
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Pending MSB byte of the word being assembled.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst)  msb_q <= 8'h00;
        else if (msb_ld) msb_q <= bus.i_rx_data;
    end

    // Sticky frame status, cleared when a new frame opens.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            ovf_q <= 1'b0;
            odd_q <= 1'b0;
            err_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
            odd_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (push_req && !push_ok) ovf_q <= 1'b1;
            if (set_odd)              odd_q <= 1'b1;
            if (set_err)              err_q <= 1'b1;
        end
    end

    // Word storage; contents reset so the show-ahead head reads zero out of reset.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            for (int i = 0; i < DEPTH_I; i++) mem[i] <= 16'h0000;
        end else if (push_ok && !clr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; push+pop leaves the count unchanged.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
        end
    end

    assign bus.o_rd_data     = mem[rd_ptr];
    assign bus.o_fifo_empty  = empty;
    assign bus.o_fifo_full   = full;
    assign bus.o_word_count  = count_q;
    assign bus.o_overflow    = ovf_q;
    assign bus.o_odd_byte    = odd_q;
    assign bus.o_frame_error = err_q;
    assign bus.o_frame_done  = (state_q == DONE);
endmodule

// File: tb/tb_ddr_rx_word_collector.sv
// Scoreboard bench for ddr_rx_word_collector: expected words queued at the LSB strobe,
// popped and compared by a monitor whenever a word leaves the FIFO.
module tb_ddr_rx_word_collector;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [15:0] expq [$];

    ddr_rx_word_collector_if #(.FIFO_AW(3)) bus ();

    ddr_rx_word_collector #(.FIFO_AW(3)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every word popped must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && bus.i_rd_en && !bus.o_fifo_empty) begin
            if (expq.size() == 0) begin
                check("unexpected_pop", {16'h0, bus.o_rd_data}, 32'hFFFF_FFFF);
            end else begin
                check("rd_data", {16'h0, bus.o_rd_data}, {16'h0, expq.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d,
                       input logic e, input logic er, input logic r);
        bus.i_frame_start   = s;
        bus.i_rx_data_valid = v;
        bus.i_rx_data       = d;
        bus.i_frame_end     = e;
        bus.i_rx_error      = er;
        bus.i_rd_en         = r;
        step();
        bus.i_frame_start   = 1'b0;
        bus.i_rx_data_valid = 1'b0;
        bus.i_frame_end     = 1'b0;
        bus.i_rx_error      = 1'b0;
        bus.i_rd_en         = 1'b0;
    endtask

    task automatic start();
        cyc(1, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic byt(input logic [7:0] d);
        cyc(0, 1, d, 0, 0, 0);
    endtask

    task automatic fin();
        cyc(0, 0, 8'h00, 1, 0, 0);
    endtask

    task automatic word(input logic [15:0] w, input logic r);
        cyc(0, 1, w[15:8], 0, 0, r);
        expq.push_back(w);
        cyc(0, 1, w[7:0], 0, 0, r);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.i_rd_en = 1'b1;
        while (!bus.o_fifo_empty && n < 64) begin
            step();
            n++;
        end
        bus.i_rd_en = 1'b0;
        check({tag, "_empty"}, {31'h0, bus.o_fifo_empty}, 32'd1);
        check({tag, "_leftover"}, expq.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        bus.i_frame_start   = 1'b0;
        bus.i_frame_end     = 1'b0;
        bus.i_rx_data       = 8'h00;
        bus.i_rx_data_valid = 1'b0;
        bus.i_rx_error      = 1'b0;
        bus.i_rd_en         = 1'b0;
        repeat (3) step();
        check("rst_empty", {31'h0, bus.o_fifo_empty}, 32'd1);
        check("rst_count", {28'h0, bus.o_word_count}, 32'd0);
        check("rst_flags", {27'h0, bus.o_fifo_full, bus.o_overflow, bus.o_odd_byte,
                            bus.o_frame_error, bus.o_frame_done}, 32'd0);
        check("rst_rd_data", {16'h0, bus.o_rd_data}, 32'd0);
        rst = 1'b1;
        step();

        // 1: two full words
        start();
        byt(8'hA5);
        expq.push_back(16'hA53C);
        byt(8'h3C);
        check("t1_latency_count", {28'h0, bus.o_word_count}, 32'd1);
        check("t1_head", {16'h0, bus.o_rd_data}, 32'hA53C);
        byt(8'h0F);
        expq.push_back(16'h0FF0);
        byt(8'hF0);
        fin();
        check("t1_done", {31'h0, bus.o_frame_done}, 32'd1);
        check("t1_count", {28'h0, bus.o_word_count}, 32'd2);
        check("t1_flags", {29'h0, bus.o_overflow, bus.o_odd_byte, bus.o_frame_error}, 32'd0);
        step();
        check("t1_done_pulse", {31'h0, bus.o_frame_done}, 32'd0);
        drain("t1");
        cyc(0, 0, 8'h00, 0, 0, 1);
        check("t1_empty_pop", {28'h0, bus.o_word_count}, 32'd0);

        // 2: odd byte at close
        start();
        byt(8'h11);
        expq.push_back(16'h1122);
        byt(8'h22);
        byt(8'h33);
`ifdef RX_COLLECT_PAD_EN
        expq.push_back(16'h3300);
`endif
        fin();
        check("t2_odd", {31'h0, bus.o_odd_byte}, 32'd1);
`ifdef RX_COLLECT_PAD_EN
        check("t2_count", {28'h0, bus.o_word_count}, 32'd2);
`else
        check("t2_count", {28'h0, bus.o_word_count}, 32'd1);
`endif
        step();
        drain("t2");

        // 3a: overflow on 9th word
        start();
        for (int k = 0; k < 8; k++) word({8'h10 + 8'(k), 8'h80 + 8'(k)}, 1'b0);
        check("t3_full", {31'h0, bus.o_fifo_full}, 32'd1);
        check("t3_count8", {28'h0, bus.o_word_count}, 32'd8);
        check("t3_no_ovf_yet", {31'h0, bus.o_overflow}, 32'd0);
        byt(8'h18);
        byt(8'h88);
        check("t3_ovf", {31'h0, bus.o_overflow}, 32'd1);
        check("t3_count_drop", {28'h0, bus.o_word_count}, 32'd8);
        fin();
        step();
        drain("t3a");

        // 3b: pop on the 9th LSB keeps it
        start();
        for (int k = 0; k < 8; k++) word({8'h20 + 8'(k), 8'h90 + 8'(k)}, 1'b0);
        byt(8'h28);
        expq.push_back(16'h2898);
        cyc(0, 1, 8'h98, 0, 0, 1);
        check("t3b_no_ovf", {31'h0, bus.o_overflow}, 32'd0);
        check("t3b_count", {28'h0, bus.o_word_count}, 32'd8);
        fin();
        step();
        drain("t3b");

        // 4: sticky error
        start();
        byt(8'h01);
        cyc(0, 0, 8'h00, 0, 1, 0);
        expq.push_back(16'h0102);
        byt(8'h02);
        fin();
        check("t4_err_done", {31'h0, bus.o_frame_error}, 32'd1);
        step();
        check("t4_err_sticky", {31'h0, bus.o_frame_error}, 32'd1);
        drain("t4");
        start();
        check("t4_err_clear", {31'h0, bus.o_frame_error}, 32'd0);
        fin();
        step();

        // 5: LSB + end same cycle, MSB + end same cycle, async reset
        start();
        byt(8'h5A);
        expq.push_back(16'h5AC3);
        cyc(0, 1, 8'hC3, 1, 0, 0);
        check("t5_done", {31'h0, bus.o_frame_done}, 32'd1);
        check("t5_odd0", {31'h0, bus.o_odd_byte}, 32'd0);
        check("t5_count", {28'h0, bus.o_word_count}, 32'd1);
        step();
        drain("t5a");
        start();
`ifdef RX_COLLECT_PAD_EN
        expq.push_back(16'h7700);
`endif
        cyc(0, 1, 8'h77, 1, 0, 0);
        check("t5_msb_end_odd", {31'h0, bus.o_odd_byte}, 32'd1);
        step();
        drain("t5b");
        start();
        byt(8'hAB);
        byt(8'hCD);
        byt(8'hEF);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_empty", {31'h0, bus.o_fifo_empty}, 32'd1);
        check("t5_rst_count", {28'h0, bus.o_word_count}, 32'd0);
        expq.delete();
        step();
        rst = 1'b1;
        byt(8'h12);
        byt(8'h34);
        fin();
        check("t5_idle_count", {28'h0, bus.o_word_count}, 32'd0);
        check("t5_idle_done", {31'h0, bus.o_frame_done}, 32'd0);
        start();
        expq.push_back(16'h5678);
        byt(8'h56);
        byt(8'h78);
        fin();
        step();
        drain("t5c");

        // 6: 20 words with interleaved pops across pointer wrap
        start();
        for (int k = 0; k < 20; k++) begin
            w = {8'(k * 7 + 1), 8'(255 - k)};
            word(w, k[0]);
        end
        fin();
        check("t6_no_ovf", {31'h0, bus.o_overflow}, 32'd0);
        step();
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
